serial_adder_4_bit: RTL and testbench
=====================================

# serial_adder_4_bit

Bit-serial ripple adder computing S = A + B + Cin one bit per clock, LSB first, behind a Start/Busy/Done handshake. It is the additive counterpart of the 4-bit subtractor: it reconstructs minuends from difference/borrow results and gives the arithmetic library a low-area sequential adder. Operands are latched on Start. The registered result is held until the next operation completes.

## Interface
- WIDTH, 4, operand and result width in bits (legal range 2..16)
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  request a new addition; sampled only in IDLE
- A  input  WIDTH  addend, sampled on the accepting edge
- B  input  WIDTH  addend, sampled on the accepting edge
- Cin  input  1  carry-in, sampled on the accepting edge
- Busy  output  1  high while an operation is in progress (state != IDLE)
- Done  output  1  single-cycle completion pulse
- S  output  WIDTH  registered sum
- Cout  output  1  registered carry-out
- Ovf  output  1  signed overflow (present only with SERIAL_ADDER_OVF_EN)

## Operation
- One clock domain (Clk). Reset is asynchronous and active-low (Rst_n).
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - Start=1 → load shift registers a_sr=A and b_sr=B, carry register c=Cin, clear bit counter; go to SHIFT.
  - Start=0 → stay in IDLE.
- SHIFT, each edge:
  - Sum bit = a_sr[0] ^ b_sr[0] ^ c.
  - New carry = majority(a_sr[0], b_sr[0], c).
  - Sum bit shifts into the MSB of s_sr; a_sr and b_sr shift right.
  - Counter increments. On the WIDTH-th SHIFT edge: copy s_sr (including the final bit) to S and the final carry to Cout; go to DONE.
- DONE: Done=1 for exactly one cycle, then go to IDLE unconditionally.
- Start is ignored in SHIFT and DONE; no queuing.
- Arithmetic is modulo 2^WIDTH. Cout is bit WIDTH of A+B+Cin.
- S and Cout change only on the completion edge. They are stable at all other times, including throughout the next operation until it completes.

## Timing
- Reset (Rst_n=0, async): state=IDLE; Busy=0, Done=0, S=0, Cout=0, Ovf=0; internal registers cleared.
- Start sampled high at edge 0 (IDLE) → Busy=1 after edge 0.
- SHIFT edges: 1..WIDTH. S, Cout and Done are updated after edge WIDTH.
- Edge WIDTH+1 → IDLE with Busy=0. A new Start is accepted at the earliest on edge WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles. For WIDTH=4, Done is high in the cycle following the 4th edge after acceptance.
- A, B and Cin may change freely after the accepting edge without affecting the result.
- Rst_n asserted mid-operation: the operation is aborted, all outputs go to reset values immediately, and no Done is produced.
- Rst_n deasserts synchronously to Clk (external synchronizer). The first Start is accepted on the first edge after deassertion.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Ovf port exists.
  - On the completion edge, Ovf = (carry into MSB) ^ (carry out of MSB), i.e. two's-complement overflow of A+B+Cin.
  - Ovf is held with S.
- Undefined: Ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then A=0000, B=0000, Cin=0, Start pulse → Done 4 cycles after acceptance; S=0000, Cout=0; Busy high for 5 cycles.
- A=1110, B=1111, Cin=0 → S=1101, Cout=1. Then A=1110, B=0011, Cin=1 → S=0010, Cout=1.
- A=0111, B=0001, Cin=0 with SERIAL_ADDER_OVF_EN → S=1000, Cout=0, Ovf=1. Then A=1000, B=1000 → S=0000, Cout=1, Ovf=1.
- Start A=0001, B=0001; on edge 2 change A=1111 and pulse Start again → result S=0010, only one Done pulse, second Start ignored.
- Start A=1111, B=1111; assert Rst_n=0 after edge 2 → S=0000, Cout=0, Busy=0 immediately, no Done. After release, A=0101, B=0011 → S=1000, Cout=0.
- Back-to-back: hold Start high continuously → operations accepted every 6 cycles. Each Done is one cycle wide. S is stable between Done pulses.

Source files
------------

// File: rtl/serial_adder_4_bit_if.sv
// ---------------------------------------------------------------------------
// serial_adder_4_bit_if
//
// Purpose: bundles the request/response signals of the bit-serial adder so
//          that a requester and the adder can be connected by one port.
//
// Parameters:
//   WIDTH  operand and result width in bits (2..16)
//
// Signals:
//   Start  requester -> adder  request a new addition (sampled only when idle)
//   A, B   requester -> adder  addends, sampled on the accepting edge
//   Cin    requester -> adder  carry-in, sampled on the accepting edge
//   Busy   adder -> requester  high while an operation is in progress
//   Done   adder -> requester  single-cycle completion pulse
//   S      adder -> requester  registered sum, held until the next completion
//   Cout   adder -> requester  registered carry-out, held with S
//   Ovf    adder -> requester  signed overflow, held with S
//                              (exists only when SERIAL_ADDER_OVF_EN is defined)
//
// Modports:
//   master  the side that issues additions
//   slave   the adder itself
// ---------------------------------------------------------------------------
interface serial_adder_4_bit_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output Start,
        output A,
        output B,
        output Cin,
        input  Busy,
        input  Done,
        input  S,
        input  Cout
`ifdef SERIAL_ADDER_OVF_EN
        ,
        input  Ovf
`endif
    );

    modport slave (
        input  Start,
        input  A,
        input  B,
        input  Cin,
        output Busy,
        output Done,
        output S,
        output Cout
`ifdef SERIAL_ADDER_OVF_EN
        ,
        output Ovf
`endif
    );
endinterface

// File: rtl/serial_adder_4_bit.sv
// ---------------------------------------------------------------------------
// serial_adder_4_bit
//
// Purpose: bit-serial ripple adder computing S = A + B + Cin, one bit per
//          clock, LSB first, behind a Start/Busy/Done handshake. Operands are
//          captured on the accepting edge; S/Cout (and Ovf) change only on the
//          completion edge and are held until the next operation completes.
//          One operation takes WIDTH+2 cycles from acceptance to the next
//          possible acceptance.
//
// Parameters:
//   WIDTH  operand and result width in bits (2..16)
//
// Optional feature (macro SERIAL_ADDER_OVF_EN):
//   When defined, the interface carries Ovf, the two's-complement overflow
//   of A+B+Cin (carry into MSB xor carry out of MSB), registered with S.
//   When undefined, the Ovf signal and its logic are absent.
//
// Ports:
//   Clk    input   rising-edge clock
//   Rst_n  input   asynchronous active-low reset (deassertion is expected to
//                  be synchronous to Clk)
//   bus    slave modport of serial_adder_4_bit_if (Start, A, B, Cin in;
//                  Busy, Done, S, Cout [, Ovf] out)
// ---------------------------------------------------------------------------
module serial_adder_4_bit #(
    parameter int WIDTH = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    serial_adder_4_bit_if.slave   bus
);

    // Counter only has to reach WIDTH-1 (the edge processing the MSB).
    localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    // Datapath registers
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] s_sr_reg;
    logic             c_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Held result registers
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_reg;
`endif

    // Combinational helpers
    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] s_shifted;
    logic             busy;
    logic             done;

    assign accept     = (state_reg == IDLE) && bus.Start;
    assign last_bit   = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);

    // One full-adder cell, reused every SHIFT cycle on the current LSBs.
    assign sum_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ c_reg;
    assign carry_next = (a_sr_reg[0] & b_sr_reg[0]) |
                        (a_sr_reg[0] & c_reg)       |
                        (b_sr_reg[0] & c_reg);

    // Sum bits enter at the MSB so that after WIDTH shifts the first
    // (least significant) bit has arrived at bit 0.
    assign s_shifted  = {sum_bit, s_sr_reg[WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. Start is only looked at in IDLE, so a request
    // raised during SHIFT or DONE is dropped rather than queued.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.Start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs, decoded from the registered state so they are glitch-free
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            SHIFT: begin
                busy = 1'b1;
                done = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift datapath: operand capture on accept, one bit per SHIFT cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_sr_reg <= '0;
            b_sr_reg <= '0;
            s_sr_reg <= '0;
            c_reg    <= 1'b0;
            cnt_reg  <= '0;
        end else if (accept) begin
            a_sr_reg <= bus.A;
            b_sr_reg <= bus.B;
            s_sr_reg <= '0;
            c_reg    <= bus.Cin;
            cnt_reg  <= '0;
        end else if (state_reg == SHIFT) begin
            a_sr_reg <= a_sr_reg >> 1;
            b_sr_reg <= b_sr_reg >> 1;
            s_sr_reg <= s_shifted;
            c_reg    <= carry_next;
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: loaded only on the edge that processes the MSB, using
    // the freshly computed bit rather than s_sr_reg, which lags by one bit.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s_reg    <= '0;
            cout_reg <= 1'b0;
        end else if (last_bit) begin
            s_reg    <= s_shifted;
            cout_reg <= carry_next;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB edge c_reg is the carry into the MSB and carry_next is the
    // carry out of it; they differ exactly when the signed result overflows.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= c_reg ^ carry_next;
        end
    end

    assign bus.Ovf  = ovf_reg;
`endif

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.S    = s_reg;
    assign bus.Cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_4_bit.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_4_bit
//
// Self-checking bench for serial_adder_4_bit. Expected results come from a
// plain-arithmetic reference model (integer addition, signed range test).
// Directed cases cover reset, carry/overflow corners, an ignored mid-op
// Start, reset mid-operation and back-to-back operation; a randomized
// section then applies $urandom operands.
// ---------------------------------------------------------------------------
module tb_serial_adder_4_bit;

    localparam int WIDTH = 4;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    serial_adder_4_bit_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_4_bit #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: S/Cout from unsigned integer sum, Ovf from whether the
    // signed sum leaves the representable two's-complement range.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, output logic [WIDTH-1:0] s,
                                  output logic cout, output logic ovf);
        int u;
        int sa;
        int sb;
        int sv;
        u    = int'(a) + int'(b) + int'(cin);
        s    = u[WIDTH-1:0];
        cout = u[WIDTH];
        sa   = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
        sb   = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
        sv   = sa + sb + int'(cin);
        ovf  = (sv > (1 << (WIDTH-1)) - 1) || (sv < -(1 << (WIDTH-1)));
    endfunction

    // Runs one operation from IDLE. Entered and left at posedge+#1 with the
    // DUT idle. Optionally re-raises Start (with a new A) mid-operation.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input bit mid_start);
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
        logic [WIDTH-1:0] held_s;
        logic             held_c;
        int               n;
        model(a, b, cin, es, ec, eo);
        held_s    = bus.S;
        held_c    = bus.Cout;
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        bus.A     = WIDTH'($urandom);
        bus.B     = WIDTH'($urandom);
        bus.Cin   = 1'($urandom);
        n = 0;
        while (!bus.Done && n < 20) begin
            check("busy_shift", 32'(bus.Busy), 32'd1);
            check("s_hold", 32'(bus.S), 32'(held_s));
            check("cout_hold", 32'(bus.Cout), 32'(held_c));
            @(posedge Clk); #1;
            n++;
            if (mid_start && n == 2) begin
                bus.Start = 1'b1;
                bus.A     = '1;
            end
            if (mid_start && n == 3) begin
                bus.Start = 1'b0;
            end
        end
        check("done_latency", 32'(n), 32'(WIDTH));
        check("busy_done", 32'(bus.Busy), 32'd1);
        check("sum", 32'(bus.S), 32'(es));
        check("cout", 32'(bus.Cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(bus.Ovf), 32'(eo));
`endif
        $display("op A=%b B=%b Cin=%b -> S=%b Cout=%b (exp %b %b) latency=%0d",
                 a, b, cin, bus.S, bus.Cout, es, ec, n);
        @(posedge Clk); #1;
        check("done_width", 32'(bus.Done), 32'd0);
        check("busy_idle", 32'(bus.Busy), 32'd0);
        if (mid_start) begin
            for (int i = 0; i < 6; i++) begin
                @(posedge Clk); #1;
                check("no_extra_done", 32'(bus.Done), 32'd0);
            end
            check("mid_start_sum", 32'(bus.S), 32'(es));
        end
    endtask

    task automatic reset_mid_op();
        bus.Start = 1'b1;
        bus.A     = 4'b1111;
        bus.B     = 4'b1111;
        bus.Cin   = 1'b0;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        @(posedge Clk);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check("rst_s", 32'(bus.S), 32'd0);
        check("rst_cout", 32'(bus.Cout), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(bus.Ovf), 32'd0);
`endif
        $display("reset asserted mid-operation: S=%b Cout=%b Busy=%b", bus.S, bus.Cout, bus.Busy);
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            check("rst_no_done", 32'(bus.Done), 32'd0);
        end
        Rst_n = 1'b1;
    endtask

    // Start held high: each accept is one cycle after the previous DONE
    // cycle's successor, so Done pulses are WIDTH+2 cycles apart.
    task automatic back_to_back();
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
        logic [WIDTH-1:0] held_s;
        int               cyc;
        int               last;
        int               ndone;
        bus.A   = WIDTH'($urandom);
        bus.B   = WIDTH'($urandom);
        bus.Cin = 1'($urandom);
        model(bus.A, bus.B, bus.Cin, es, ec, eo);
        held_s    = bus.S;
        bus.Start = 1'b1;
        last  = 0;
        ndone = 0;
        for (cyc = 1; cyc <= 59; cyc++) begin
            @(posedge Clk); #1;
            if (bus.Done) begin
                check("b2b_sum", 32'(bus.S), 32'(es));
                check("b2b_cout", 32'(bus.Cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
                check("b2b_ovf", 32'(bus.Ovf), 32'(eo));
`endif
                if (ndone > 0) begin
                    check("b2b_gap", 32'(cyc - last), 32'(WIDTH + 2));
                end
                $display("b2b done at cycle %0d: S=%b Cout=%b (exp %b %b)", cyc, bus.S, bus.Cout, es, ec);
                last   = cyc;
                ndone++;
                held_s = bus.S;
                bus.A   = WIDTH'($urandom);
                bus.B   = WIDTH'($urandom);
                bus.Cin = 1'($urandom);
                model(bus.A, bus.B, bus.Cin, es, ec, eo);
            end else begin
                check("b2b_s_stable", 32'(bus.S), 32'(held_s));
            end
        end
        bus.Start = 1'b0;
        check("b2b_count", 32'(ndone), 32'd10);
        @(posedge Clk);
        @(posedge Clk); #1;
        check("b2b_idle", 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_busy", 32'(bus.Busy), 32'd0);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_s", 32'(bus.S), 32'd0);
        check("reset_cout", 32'(bus.Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf", 32'(bus.Ovf), 32'd0);
`endif
        Rst_n = 1'b1;

        run_op(4'b0000, 4'b0000, 1'b0, 1'b0);
        run_op(4'b1110, 4'b1111, 1'b0, 1'b0);
        run_op(4'b1110, 4'b0011, 1'b1, 1'b0);
        run_op(4'b0111, 4'b0001, 1'b0, 1'b0);
        run_op(4'b1000, 4'b1000, 1'b0, 1'b0);
        run_op(4'b1111, 4'b0000, 1'b1, 1'b0);
        run_op(4'b0001, 4'b0001, 1'b0, 1'b1);
        run_op(4'b1110, 4'b1111, 1'b0, 1'b0);
        reset_mid_op();
        run_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "timeout");
    end

endmodule
